// File: rtl/tail_lights_pkg.sv
// Shared types and helpers for the tail-light sequencer.
package tail_lights_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LSEQ   = 2'd1,
        RSEQ   = 2'd2,
        HAZ_ON = 2'd3
    } state_t;

    localparam int unsigned MASK_W  = 8;
    localparam int unsigned MASK_CW = 3;

    // Thermometer mask: bits 0..cnt set, wide enough for the largest lamp count.
    function automatic logic [MASK_W-1:0] thermo_mask(input logic [MASK_CW-1:0] cnt);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            m[i] = (i <= 32'(cnt));
        end
        return m;
    endfunction

endpackage

// File: rtl/tail_lights_gen_if.sv
// Request inputs and lamp outputs of the tail-light sequencer.
interface tail_lights_gen_if #(
    parameter int unsigned N_PER_SIDE = 3
);
    logic                  LEFT;
    logic                  RIGHT;
    logic                  HAZ;
    logic                  BRAKE;
    logic [N_PER_SIDE-1:0] LIGHTS_L;
    logic [N_PER_SIDE-1:0] LIGHTS_R;
    logic                  BUSY;

    modport master (
        output LEFT, RIGHT, HAZ, BRAKE,
        input  LIGHTS_L, LIGHTS_R, BUSY
    );

    modport slave (
        input  LEFT, RIGHT, HAZ, BRAKE,
        output LIGHTS_L, LIGHTS_R, BUSY
    );
endinterface

// File: rtl/tail_lights_tick.sv
// Step prescaler: STEP is high in the last cycle of every TICK_DIV-cycle period.
module tail_lights_tick #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic CLOCK,
    input  logic RESET_N,
    output logic STEP
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign STEP = (count == LAST);
endmodule

// File: rtl/tail_lights_gen.sv
// Turn / hazard / brake tail-light sequencer with registered lamp outputs.
module tail_lights_gen
    import tail_lights_pkg::*;
#(
    parameter int unsigned N_PER_SIDE = 3,
    parameter int unsigned TICK_DIV   = 1
) (
    input logic            CLOCK,
    input logic            RESET_N,
    tail_lights_gen_if.slave bus
);
    localparam int unsigned CW = (N_PER_SIDE > 1) ? $clog2(N_PER_SIDE) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(N_PER_SIDE - 1);
    localparam logic [N_PER_SIDE-1:0] ALL_ON   = '1;

    logic                  step;
    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         next_cnt;
    logic [N_PER_SIDE-1:0] lights_l_c;
    logic [N_PER_SIDE-1:0] lights_r_c;
    logic                  busy_c;

    tail_lights_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .STEP    (step)
    );

    // State, step index and lamp registers.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.LIGHTS_L <= '0;
            bus.LIGHTS_R <= '0;
            bus.BUSY     <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            bus.LIGHTS_L <= lights_l_c;
            bus.LIGHTS_R <= lights_r_c;
            bus.BUSY     <= busy_c;
        end
    end

    // Transitions happen only on STEP; a reached last lamp beats any abort.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (step) begin
            case (state)
                IDLE: begin
                    next_cnt = '0;
                    if (bus.HAZ || (bus.LEFT && bus.RIGHT)) next_state = HAZ_ON;
                    else if (bus.LEFT)                      next_state = LSEQ;
                    else if (bus.RIGHT)                     next_state = RSEQ;
                end
                LSEQ: begin
                    if (cnt == CNT_LAST) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else if (bus.HAZ) begin
                        next_state = HAZ_ON;
                        next_cnt   = '0;
                    end else if (bus.RIGHT) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CW'(1);
                    end
                end
                RSEQ: begin
                    if (cnt == CNT_LAST) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else if (bus.HAZ) begin
                        next_state = HAZ_ON;
                        next_cnt   = '0;
                    end else if (bus.LEFT) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CW'(1);
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Lamp decode of the upcoming state; BRAKE lights every side not turning.
    always_comb begin
        lights_l_c = bus.BRAKE ? ALL_ON : '0;
        lights_r_c = bus.BRAKE ? ALL_ON : '0;
        busy_c     = 1'b0;
        case (next_state)
            LSEQ: begin
                lights_l_c = N_PER_SIDE'(thermo_mask(MASK_CW'(next_cnt)));
                busy_c     = 1'b1;
            end
            RSEQ: begin
                lights_r_c = N_PER_SIDE'(thermo_mask(MASK_CW'(next_cnt)));
                busy_c     = 1'b1;
            end
            HAZ_ON: begin
                lights_l_c = ALL_ON;
                lights_r_c = ALL_ON;
                busy_c     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
